// File: rtl/data_memory_pipe_if.sv
// data_memory_pipe_if: request/response bus of the pipelined data memory
interface data_memory_pipe_if #(parameter int DATA_W = 32);
  logic in_ctrl_read, in_ctrl_write, in_ctrl_clear;
  logic [31:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W/8-1:0] in_byte_en;
  logic out_ready, out_valid, out_rerr, out_werr;
  logic [DATA_W-1:0] out_data;
  modport master (
    output in_ctrl_read, in_ctrl_write, in_ctrl_clear, in_addr, in_data, in_byte_en,
    input out_ready, out_valid, out_rerr, out_werr, out_data
  );
  modport slave (
    input in_ctrl_read, in_ctrl_write, in_ctrl_clear, in_addr, in_data, in_byte_en,
    output out_ready, out_valid, out_rerr, out_werr, out_data
  );
endinterface

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-enabled word memory with pipelined reads and a clear sweep
module data_memory_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int INIT_MODE = 1
) (
  input logic in_clk,
  input logic in_rst,
  data_memory_pipe_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB = DATA_W / 8;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return INIT_MODE == 1 ? DATA_W'(a) : '0;
  endfunction
  // Words are stored XORed with the init pattern: the all-zero power-up
  // image therefore reads back as the pattern, and a clear just writes zeros.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, idx;
  logic in_rng, acc_rd, acc_wr, acc_clr, clr_done;
  logic [DATA_W-1:0] mask, cur, merged, rd_word;
  logic [RD_LAT-1:0] p_v, p_e;
  logic [DATA_W-1:0] p_d [RD_LAT];
  assign idx = bus.in_addr[ADDR_W-1:0];
  assign in_rng = (bus.in_addr >> ADDR_W) == 32'd0;
  assign acc_clr = bus.out_ready && bus.in_ctrl_clear;
  assign acc_rd = bus.out_ready && bus.in_ctrl_read && !bus.in_ctrl_clear;
  assign acc_wr = bus.out_ready && bus.in_ctrl_write && !bus.in_ctrl_clear;
  assign clr_done = state == CLEAR && cnt == '1;
  // FSM output: requests are taken only when idle and out of reset
  always_comb bus.out_ready = state == IDLE && !in_rst;
  // FSM next state: clear sweeps until the last word, then returns to idle
  always_comb state_nx = state == IDLE ? (acc_clr ? CLEAR : IDLE) : (clr_done ? IDLE : CLEAR);
  // FSM state register and clear counter
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
    end
  end
  // Byte-merge the write word; a same-edge read sees the merged word
  always_comb begin
    mask = '0;
    for (int k = 0; k < NB; k++) mask[8*k +: 8] = {8{bus.in_byte_en[k]}};
    cur = mem[idx] ^ pat(idx);
    merged = (cur & ~mask) | (bus.in_data & mask);
    rd_word = !in_rng ? '0 : acc_wr ? merged : cur;
  end
  // Memory array: clear sweep or in-range byte-merged write, never touched by reset
  always_ff @(posedge in_clk) begin
    if (state == CLEAR) mem[cnt] <= '0;
    else if (acc_wr && in_rng) mem[idx] <= merged ^ pat(idx);
  end
  // Sticky out-of-range write flag, cleared when a clear sweep completes
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) bus.out_werr <= 1'b0;
    else if (clr_done) bus.out_werr <= 1'b0;
    else if (acc_wr && !in_rng) bus.out_werr <= 1'b1;
  end
  // Read pipeline; data only advances with a valid so the last stage holds
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      p_v <= '0;
      p_e <= '0;
      for (int k = 0; k < RD_LAT; k++) p_d[k] <= '0;
    end else begin
      p_v[0] <= acc_rd;
      p_e[0] <= acc_rd && !in_rng;
      if (acc_rd) p_d[0] <= rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
        p_v[k] <= p_v[k-1];
        p_e[k] <= p_e[k-1];
        if (p_v[k-1]) p_d[k] <= p_d[k-1];
      end
    end
  end
  assign bus.out_valid = p_v[RD_LAT-1];
  assign bus.out_rerr = p_e[RD_LAT-1];
  assign bus.out_data = p_d[RD_LAT-1];
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed self-checking bench for data_memory_pipe
module tb_data_memory_pipe;
  logic clk = 0, rst_a = 1, rst_b = 1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_memory_pipe_if #(.DATA_W(32)) ba ();
  data_memory_pipe_if #(.DATA_W(32)) bb ();
  data_memory_pipe #(.DATA_W(32), .ADDR_W(16), .RD_LAT(2), .INIT_MODE(1)) dut_a (
    .in_clk(clk), .in_rst(rst_a), .bus(ba)
  );
  data_memory_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .INIT_MODE(1)) dut_b (
    .in_clk(clk), .in_rst(rst_b), .bus(bb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ba.in_addr = a; ba.in_data = d; ba.in_byte_en = be; ba.in_ctrl_write = 1;
    tick();
    ba.in_ctrl_write = 0;
  endtask

  task automatic wr_b(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bb.in_addr = a; bb.in_data = d; bb.in_byte_en = be; bb.in_ctrl_write = 1;
    tick();
    bb.in_ctrl_write = 0;
  endtask

  task automatic rd_a(input logic [31:0] a, output logic [31:0] d, output logic e, output bit ok);
    ba.in_addr = a; ba.in_ctrl_read = 1;
    tick();
    ba.in_ctrl_read = 0;
    ok = 0; d = 0; e = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (ba.out_valid === 1'b1) begin ok = 1; d = ba.out_data; e = ba.out_rerr; end
    end
  endtask

  task automatic rd_b(input logic [31:0] a, output logic [31:0] d, output logic e, output bit ok);
    bb.in_addr = a; bb.in_ctrl_read = 1;
    tick();
    bb.in_ctrl_read = 0;
    ok = 0; d = 0; e = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bb.out_valid === 1'b1) begin ok = 1; d = bb.out_data; e = bb.out_rerr; end
    end
  endtask

  task automatic test_reset;
    tick(); tick();
    n_chk++; if (ba.out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ba.out_ready); end
    n_chk++; if (ba.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ba.out_valid); end
    n_chk++; if (ba.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", ba.out_data); end
    n_chk++; if (ba.out_rerr !== 1'b0) begin n_fail++; $display("FAIL reset_rerr: got %b want 0", ba.out_rerr); end
    n_chk++; if (ba.out_werr !== 1'b0) begin n_fail++; $display("FAIL reset_werr: got %b want 0", ba.out_werr); end
    rst_a = 0; rst_b = 0;
    #1;
    n_chk++; if (ba.out_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_a: got %b want 1", ba.out_ready); end
    n_chk++; if (bb.out_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_b: got %b want 1", bb.out_ready); end
    tick();
  endtask

  task automatic test_read_latency;
    ba.in_addr = 32'h100; ba.in_ctrl_read = 1;
    tick();
    ba.in_ctrl_read = 0;
    n_chk++; if (ba.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid: got %b want 0", ba.out_valid); end
    tick();
    n_chk++; if (ba.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b want 1", ba.out_valid); end
    n_chk++; if (ba.out_data !== 32'h100) begin n_fail++; $display("FAIL lat_data: got %h want 00000100", ba.out_data); end
    n_chk++; if (ba.out_rerr !== 1'b0) begin n_fail++; $display("FAIL lat_rerr: got %b want 0", ba.out_rerr); end
    tick();
    n_chk++; if (ba.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pulse_len: got %b want 0", ba.out_valid); end
    n_chk++; if (ba.out_data !== 32'h100) begin n_fail++; $display("FAIL lat_hold: got %h want 00000100", ba.out_data); end
  endtask

  task automatic test_byte_en;
    logic [31:0] d; logic e; bit ok;
    wr_a(32'h20, 32'hAABBCCDD, 4'b0101);
    rd_a(32'h20, d, e, ok);
    n_chk++; if (!ok || d !== 32'h00BB00DD) begin n_fail++; $display("FAIL byte_en_merge: got %h (ok=%0d) want 00bb00dd", d, ok); end
    wr_a(32'h21, 32'hFFFFFFFF, 4'b0000);
    rd_a(32'h21, d, e, ok);
    n_chk++; if (!ok || d !== 32'h21) begin n_fail++; $display("FAIL byte_en_none: got %h (ok=%0d) want 00000021", d, ok); end
  endtask

  task automatic test_same_edge;
    logic [31:0] d; logic e; bit ok;
    ba.in_addr = 32'h40; ba.in_data = 32'h12345678; ba.in_byte_en = 4'hF;
    ba.in_ctrl_read = 1; ba.in_ctrl_write = 1;
    tick();
    ba.in_ctrl_read = 0; ba.in_ctrl_write = 0;
    tick();
    n_chk++; if (ba.out_valid !== 1'b1 || ba.out_data !== 32'h12345678) begin n_fail++; $display("FAIL same_edge_rw: got v=%b %h want v=1 12345678", ba.out_valid, ba.out_data); end
    ba.in_addr = 32'h50; ba.in_ctrl_read = 1;
    tick();
    ba.in_ctrl_read = 0; ba.in_data = 32'hCAFEF00D; ba.in_ctrl_write = 1;
    tick();
    ba.in_ctrl_write = 0;
    n_chk++; if (ba.out_valid !== 1'b1 || ba.out_data !== 32'h50) begin n_fail++; $display("FAIL read_snapshot: got v=%b %h want v=1 00000050", ba.out_valid, ba.out_data); end
    rd_a(32'h50, d, e, ok);
    n_chk++; if (!ok || d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL later_write: got %h (ok=%0d) want cafef00d", d, ok); end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 6; j++) begin
      ba.in_ctrl_read = j < 4;
      ba.in_addr = 32'h100 + j;
      tick();
      n_chk++; if (ba.out_valid !== (j >= 1 && j <= 4)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", j, ba.out_valid, j >= 1 && j <= 4); end
      if (j >= 1 && j <= 4) begin
        n_chk++; if (ba.out_data !== 32'h100 + j - 1) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", j, ba.out_data, 32'h100 + j - 1); end
      end
    end
    ba.in_ctrl_read = 0;
  endtask

  task automatic test_out_of_range;
    logic [31:0] d; logic e; bit ok;
    rd_a(32'h0001_0000, d, e, ok);
    n_chk++; if (!ok || d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL oor_read: got %h rerr=%b (ok=%0d) want 0 rerr=1", d, e, ok); end
    n_chk++; if (ba.out_werr !== 1'b0) begin n_fail++; $display("FAIL oor_werr_pre: got %b want 0", ba.out_werr); end
    wr_a(32'h0001_0000, 32'hDEADBEEF, 4'hF);
    n_chk++; if (ba.out_werr !== 1'b1) begin n_fail++; $display("FAIL oor_werr_set: got %b want 1", ba.out_werr); end
    tick(); tick(); tick();
    n_chk++; if (ba.out_werr !== 1'b1) begin n_fail++; $display("FAIL oor_werr_sticky: got %b want 1", ba.out_werr); end
    rd_a(32'h0, d, e, ok);
    n_chk++; if (!ok || d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL oor_mem_unchanged: got %h rerr=%b want 0 rerr=0", d, e); end
  endtask

  task automatic test_clear;
    logic [31:0] d; logic e; bit ok;
    int n0 = 0;
    for (int i = 0; i < 16; i++) wr_b(i, 32'hF000_0000 | i, 4'hF);
    wr_b(32'h10, 32'h0, 4'hF);
    n_chk++; if (bb.out_werr !== 1'b1) begin n_fail++; $display("FAIL clr_werr_set: got %b want 1", bb.out_werr); end
    bb.in_addr = 32'h3; bb.in_ctrl_read = 1;
    tick();
    bb.in_addr = 32'h5; bb.in_ctrl_clear = 1;
    tick();
    bb.in_ctrl_read = 0; bb.in_ctrl_clear = 0;
    n_chk++; if (bb.out_valid !== 1'b1 || bb.out_data !== 32'hF000_0003) begin n_fail++; $display("FAIL clr_drain: got v=%b %h want v=1 f0000003", bb.out_valid, bb.out_data); end
    for (int i = 0; i < 40 && bb.out_ready === 1'b0; i++) begin
      n0++;
      if (i == 1) begin
        n_chk++; if (bb.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_drop_read: got %b want 0", bb.out_valid); end
      end
      tick();
    end
    n_chk++; if (n0 != 16) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d want 16", n0); end
    n_chk++; if (bb.out_werr !== 1'b0) begin n_fail++; $display("FAIL clr_werr_cleared: got %b want 0", bb.out_werr); end
    for (int i = 0; i < 16; i++) begin
      rd_b(i, d, e, ok);
      n_chk++; if (!ok || d !== i) begin n_fail++; $display("FAIL clr_word[%0d]: got %h (ok=%0d) want %h", i, d, ok, i); end
    end
  endtask

  task automatic test_clear_abort;
    logic [31:0] d; logic e; bit ok;
    for (int i = 0; i < 16; i++) wr_b(i, 32'hF000_0000 | i, 4'hF);
    bb.in_ctrl_clear = 1;
    tick();
    bb.in_ctrl_clear = 0;
    repeat (5) tick();
    rst_b = 1;
    #1;
    n_chk++; if (bb.out_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_rst: got %b want 0", bb.out_ready); end
    tick();
    rst_b = 0;
    #1;
    n_chk++; if (bb.out_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_release: got %b want 1", bb.out_ready); end
    for (int i = 0; i < 16; i++) begin
      rd_b(i, d, e, ok);
      n_chk++; if (!ok || d !== (i < 5 ? i : 32'hF000_0000 | i)) begin n_fail++; $display("FAIL abort_word[%0d]: got %h (ok=%0d) want %h", i, d, ok, i < 5 ? i : 32'hF000_0000 | i); end
    end
    bb.in_addr = 32'h2; bb.in_ctrl_read = 1;
    tick();
    bb.in_ctrl_read = 0;
    rst_b = 1;
    #1;
    tick();
    rst_b = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bb.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard[%0d]: got %b want 0", i, bb.out_valid); end
    end
  endtask

  initial begin
    ba.in_ctrl_read = 0; ba.in_ctrl_write = 0; ba.in_ctrl_clear = 0;
    ba.in_addr = 0; ba.in_data = 0; ba.in_byte_en = 0;
    bb.in_ctrl_read = 0; bb.in_ctrl_write = 0; bb.in_ctrl_clear = 0;
    bb.in_addr = 0; bb.in_data = 0; bb.in_byte_en = 0;
    test_reset();
    test_read_latency();
    test_byte_en();
    test_same_edge();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_clear_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
